uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Boot-time loader that sits directly upstream of the CPU's program memory. It receives a program image over the CPU's UART receive line and assembles little-endian 32-bit instruction words. Each word is written into program memory at consecutive byte addresses 0, 4, 8, …. When the image is complete it raises `load_done`, which the top level uses to release the CPU pipeline from reset.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `PROGRAM_MEMORY_ADDRESS_BITWIDTH`, default 14: width of the program-memory byte address.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  UART receive line, asynchronous to `clk`; idles high; 8N1 format, LSB first.
- `pm_wr_en`  out  1  one-cycle write strobe to program memory.
- `pm_wr_address`  out  `PROGRAM_MEMORY_ADDRESS_BITWIDTH`  byte address of the word being written; always a multiple of 4.
- `pm_wr_data`  out  32  instruction word being written.
- `load_done`  out  1  image fully written; sticky until `reset`.
- `frame_error`  out  1  sticky; set when any byte has a stop bit of 0.
- `checksum_error`  out  1  sticky; image checksum mismatch. Constant 0 when checksum checking is compiled out.

## Operation
- **Reset values.** Every output is 0. The RX FSM is in IDLE, the loader FSM is in HEADER, and all counters and shift registers are 0.
- **Synchronizer.** `uart_rxd` passes through a 2-flop synchronizer with both flops reset to 1. All decoding uses the synchronized value.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized 1→0 transition.
  - START waits `CLK_PER_BIT/2` cycles (integer division), then re-samples. If the line is high again (false start), return to IDLE. Otherwise go to DATA.
  - DATA samples 8 bits, one every `CLK_PER_BIT` cycles, shifted in LSB first.
  - STOP samples once, `CLK_PER_BIT` cycles after bit 7.
    - Stop bit = 1: pulse internal `byte_valid` for 1 cycle with the byte.
    - Stop bit = 0: set `frame_error` and discard the byte.
  - Either way, return to IDLE in the cycle after the stop sample, so back-to-back frames are accepted.
- **Loader FSM states:** HEADER, PROGRAM, CHECK, DONE.
  - HEADER: the first 4 valid bytes form a 32-bit little-endian word count N.
    - N = 0 (and no checksum): go to DONE.
    - Otherwise: go to PROGRAM.
  - PROGRAM: bytes fill a 32-bit word little-endian; the first byte lands in bits [7:0].
    - On the 4th byte, issue the write: `pm_wr_address` = word_index × 4, truncated to `PROGRAM_MEMORY_ADDRESS_BITWIDTH` (wraps modulo the memory size), and `pm_wr_data` = the word.
    - Then word_index increments.
    - After word N−1, go to CHECK if checksum is enabled, else to DONE.
  - CHECK: see Configuration.
  - DONE: `load_done` = 1. All further bytes are ignored and `pm_wr_en` stays 0. Only `reset` leaves DONE.
- A framing-error byte does not advance any loader counter.
- A reset asserted mid-frame or mid-image aborts immediately. Partially assembled words are discarded and the whole protocol restarts from HEADER.

## Timing
- Start edge detection lags the line by 2 cycles (synchronizer) plus 1 cycle (edge detect).
- The data-bit k sample falls `CLK_PER_BIT/2 + (k+1)·CLK_PER_BIT` cycles after the detected edge; the stop sample at k = 8.
- `byte_valid` is asserted in the cycle after the stop sample.
- `pm_wr_en`, `pm_wr_address` and `pm_wr_data` are registered. They are valid in the cycle after the 4th `byte_valid` of a word, and `pm_wr_en` is high for exactly 1 cycle.
- `pm_wr_address` and `pm_wr_data` hold their last values between strobes.
- `load_done` rises in the cycle after the final `pm_wr_en` pulse. For N = 0, it rises in the cycle after the 4th header byte.
- `frame_error` rises in the cycle after a bad stop sample.

## Configuration
- **`UART_LOADER_CHECKSUM_EN` defined:**
  - One extra byte follows the last program word. It equals the XOR of all program bytes; header bytes are excluded.
  - CHECK compares this byte with the running XOR, which is 0 for N = 0.
  - Match: go to DONE.
  - Mismatch: set `checksum_error` and stay in CHECK. `load_done` is never raised, so the CPU stays in reset until `reset`.
- **Not defined:**
  - No checksum byte is expected; CHECK is unreachable.
  - `checksum_error` is tied to 0.

## Test plan
All scenarios use `CLK_PER_BIT` = 8.
- Reset mid-frame with `uart_rxd` low → all outputs read 0 while reset is high and 1 cycle after release; the next frame is decoded correctly.
- Bytes 02 00 00 00, 93 00 00 00, 13 05 10 00 (checksum compiled out) → two writes: (addr 0, 0x00000093), then (addr 4, 0x00100513), each a 1-cycle strobe; `load_done` = 1 the cycle after the second strobe.
- Header 00 00 00 00 → no `pm_wr_en`; `load_done` = 1 the cycle after the 4th byte; subsequent byte 0xFF produces no write.
- Frame 0x55 with stop bit 0, then header 01 00 00 00 and word bytes EF BE AD DE → `frame_error` = 1; the bad byte is ignored; one write (addr 0, 0xDEADBEEF); `load_done` = 1.
- `uart_rxd` low pulse of 2 cycles, then idle → no byte accepted; no output change.
- With `UART_LOADER_CHECKSUM_EN`: header 01 00 00 00, word 01 02 04 08, checksum 0x0F → `load_done` = 1. Same stimulus with checksum 0x0E → `checksum_error` = 1, `load_done` stays 0.

Source files
------------

// File: rtl/uart_program_loader.sv
`timescale 1ns/1ps
// UART boot loader: decodes 8N1 bytes, reads a word-count header, then writes little-endian
// 32-bit words to program memory. Optional checksum byte enabled by UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int CLK_PER_BIT                     = 868,
  parameter int PROGRAM_MEMORY_ADDRESS_BITWIDTH = 14
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       uart_rxd,
  output logic                                       pm_wr_en,
  output logic [PROGRAM_MEMORY_ADDRESS_BITWIDTH-1:0] pm_wr_address,
  output logic [31:0]                                pm_wr_data,
  output logic                                       load_done,
  output logic                                       frame_error,
  output logic                                       checksum_error
);

  localparam int AW = PROGRAM_MEMORY_ADDRESS_BITWIDTH;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_HEADER, LD_PROGRAM, LD_CHECK, LD_DONE} ld_state_t;

  rx_state_t       rx_state, rx_next;
  ld_state_t       ld_state, ld_next;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic            fall, tick;

  logic [1:0]      byte_cnt;
  logic [23:0]     word_asm;
  logic [31:0]     word_count;
  logic [31:0]     word_index;
  logic [31:0]     assembled;
  logic            last_byte;

  assign fall = rx_prev & ~rx_s2;
  assign tick = (rx_cnt == '0);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_next = RX_START;
      RX_START: if (tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Down-counter is reloaded with the half-bit count whenever idle so the start
  // re-sample lands mid-bit; every later sample is one full bit period further.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_cnt      <= '0;
      bit_idx     <= '0;
      rx_shift    <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_s1      <= uart_rxd;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      rx_state   <= rx_next;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= HALF_LAST;
          bit_idx <= '0;
        end
        RX_START: rx_cnt <= tick ? BIT_LAST : rx_cnt - CW'(1);
        RX_DATA: begin
          if (tick) begin
            rx_cnt   <= BIT_LAST;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_cnt <= HALF_LAST;
            if (rx_s2) byte_valid  <= 1'b1;
            else       frame_error <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        default: rx_cnt <= HALF_LAST;
      endcase
    end
  end

  assign assembled = {rx_shift, word_asm};
  assign last_byte = byte_valid && (byte_cnt == 2'd3);

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  // PROGRAM exits one cycle after the final strobe so load_done trails it.
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_HEADER: begin
        if (last_byte) begin
          if (assembled == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            ld_next = LD_CHECK;
`else
            ld_next = LD_DONE;
`endif
          end else begin
            ld_next = LD_PROGRAM;
          end
        end
      end
      LD_PROGRAM: begin
        if (pm_wr_en && word_index == word_count) begin
`ifdef UART_LOADER_CHECKSUM_EN
          ld_next = LD_CHECK;
`else
          ld_next = LD_DONE;
`endif
        end
      end
      LD_CHECK: begin
`ifdef UART_LOADER_CHECKSUM_EN
        if (byte_valid && rx_shift == csum) ld_next = LD_DONE;
`endif
      end
      LD_DONE:  ld_next = LD_DONE;
      default:  ld_next = LD_HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state      <= LD_HEADER;
      byte_cnt      <= '0;
      word_asm      <= '0;
      word_count    <= '0;
      word_index    <= '0;
      pm_wr_en      <= 1'b0;
      pm_wr_address <= '0;
      pm_wr_data    <= '0;
    end else begin
      ld_state <= ld_next;
      pm_wr_en <= 1'b0;
      if (byte_valid && (ld_state == LD_HEADER || ld_state == LD_PROGRAM)) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_asm <= {rx_shift, word_asm[23:8]};
      end
      if (ld_state == LD_HEADER && last_byte)
        word_count <= assembled;
      if (ld_state == LD_PROGRAM && last_byte) begin
        pm_wr_en      <= 1'b1;
        pm_wr_address <= {word_index[AW-3:0], 2'b00};
        pm_wr_data    <= assembled;
        word_index    <= word_index + 32'd1;
      end
    end
  end

  assign load_done = (ld_state == LD_DONE);

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum           <= '0;
      checksum_error <= 1'b0;
    end else begin
      if (ld_state == LD_PROGRAM && byte_valid)
        csum <= csum ^ rx_shift;
      if (ld_state == LD_CHECK && byte_valid && rx_shift != csum)
        checksum_error <= 1'b1;
    end
  end
`else
  assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_program_loader: expected writes are queued by the stimulus
// and popped by a monitor whenever pm_wr_en is seen.
module tb_uart_program_loader;
  localparam int CPB = 8;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rxd = 1'b1;
  logic          pm_wr_en;
  logic [AW-1:0] pm_wr_address;
  logic [31:0]   pm_wr_data;
  logic          load_done;
  logic          frame_error;
  logic          checksum_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_PER_BIT(CPB),
    .PROGRAM_MEMORY_ADDRESS_BITWIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rxd(uart_rxd),
    .pm_wr_en(pm_wr_en),
    .pm_wr_address(pm_wr_address),
    .pm_wr_data(pm_wr_data),
    .load_done(load_done),
    .frame_error(frame_error),
    .checksum_error(checksum_error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks = 0;
  int  errors = 0;
  bit  prev_wr = 1'b0;
  bit  final_expected = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_wr = 1'b0;
    end else begin
      if (prev_wr) begin
        chk("strobe_width", {63'd0, pm_wr_en}, 64'd0);
        if (final_expected && exp_q.size() == 0) begin
          chk("done_after_last_write", {63'd0, load_done}, 64'd1);
          final_expected = 1'b0;
        end
      end
      if (pm_wr_en && !prev_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                   pm_wr_address, pm_wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("wr_addr", {50'd0, pm_wr_address}, {50'd0, exp_e.addr});
          chk("wr_data", {32'd0, pm_wr_data}, {32'd0, exp_e.data});
          chk("done_before_write", {63'd0, load_done}, 64'd0);
        end
      end
      prev_wr = pm_wr_en;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic wr_t mk(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  function automatic logic [63:0] all_outs();
    return {14'd0, pm_wr_en, pm_wr_address, pm_wr_data, load_done, frame_error, checksum_error};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // partial image, then reset in the middle of a frame with the line low
    send4(32'h0000_0001);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs_in_reset", all_outs(), 64'd0);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("outputs_after_reset", all_outs(), 64'd0);

    // two-word image
    exp_q.push_back(mk(14'd0, 32'h0000_0093));
    exp_q.push_back(mk(14'd4, 32'h0010_0513));
`ifndef UART_LOADER_CHECKSUM_EN
    final_expected = 1'b1;
`endif
    send4(32'h0000_0002);
    send4(32'h0000_0093);
    send4(32'h0010_0513);
`ifdef UART_LOADER_CHECKSUM_EN
    send_frame(8'h95, 1'b1);
`endif
    chk("t2_writes_left", 64'(exp_q.size()), 64'd0);
    chk("t2_done_timing_seen", {63'd0, final_expected}, 64'd0);
    chk("t2_load_done", {63'd0, load_done}, 64'd1);
    chk("t2_frame_error", {63'd0, frame_error}, 64'd0);

    // empty image, later bytes ignored
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'h00, 1'b1);
    chk("t3_done_early", {63'd0, load_done}, 64'd0);
    send_frame(8'h00, 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
    send_frame(8'h00, 1'b1);
`endif
    chk("t3_load_done", {63'd0, load_done}, 64'd1);
    send_frame(8'hFF, 1'b1);
    chk("t3_done_sticky", {63'd0, load_done}, 64'd1);
    chk("t3_no_write_data", {32'd0, pm_wr_data}, 64'd0);

    // framing error byte is dropped
    do_reset();
    send_frame(8'h55, 1'b0);
    chk("t4_frame_error", {63'd0, frame_error}, 64'd1);
    chk("t4_done_early", {63'd0, load_done}, 64'd0);
    exp_q.push_back(mk(14'd0, 32'hDEAD_BEEF));
`ifndef UART_LOADER_CHECKSUM_EN
    final_expected = 1'b1;
`endif
    send4(32'h0000_0001);
    send4(32'hDEAD_BEEF);
`ifdef UART_LOADER_CHECKSUM_EN
    send_frame(8'h22, 1'b1);
`endif
    chk("t4_writes_left", 64'(exp_q.size()), 64'd0);
    chk("t4_load_done", {63'd0, load_done}, 64'd1);
    chk("t4_frame_error_sticky", {63'd0, frame_error}, 64'd1);

    // 2-cycle glitch must not start a byte
    do_reset();
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("t5_outputs_quiet", all_outs(), 64'd0);
    for (int i = 0; i < 3; i++) send_frame(8'h00, 1'b1);
    chk("t5_no_spurious_byte", {63'd0, load_done}, 64'd0);
    send_frame(8'h00, 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
    send_frame(8'h00, 1'b1);
`endif
    chk("t5_load_done", {63'd0, load_done}, 64'd1);
    chk("t5_frame_error", {63'd0, frame_error}, 64'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back(mk(14'd0, 32'h0804_0201));
    send4(32'h0000_0001);
    send4(32'h0804_0201);
    send_frame(8'h0F, 1'b1);
    chk("t6_good_done", {63'd0, load_done}, 64'd1);
    chk("t6_good_cserr", {63'd0, checksum_error}, 64'd0);
    do_reset();
    exp_q.push_back(mk(14'd0, 32'h0804_0201));
    send4(32'h0000_0001);
    send4(32'h0804_0201);
    send_frame(8'h0E, 1'b1);
    chk("t6_bad_cserr", {63'd0, checksum_error}, 64'd1);
    chk("t6_bad_done", {63'd0, load_done}, 64'd0);
    chk("t6_writes_left", 64'(exp_q.size()), 64'd0);
`else
    chk("checksum_error_tied", {63'd0, checksum_error}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
